branch_resolve_unit: RTL

Registered, parametrised branch-decision unit for the multicycle datapath. It takes two ALU-width operands plus a 3-bit condition code and resolves the branch over a fixed two-cycle pipeline. It then drives the PC write enable. It extends the original four-condition PC-write mux with signed/unsigned compare, eight conditions, a valid/ready handshake and optional branch statistics.

---
 rtl/branch_resolve_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: registered two-cycle branch decision unit.
// Latches a compare request in IDLE, computes gt/eq/lt in CMP and evaluates
// the condition code in RES. The result appears as a one-cycle done/taken pulse,
// and the unit then drives the PC write enable.
//
// Optional feature macro: BRANCH_STATS_EN adds saturating taken/not-taken counters.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid / req_ready    : request handshake (ready low while busy)
//   op_a, op_b, is_unsigned  : compare operands and signedness
//   branch_ctrl              : 3-bit condition code
//   PCWrite, PCWriteCond     : unconditional / conditional PC write from control
//   done, taken              : one-cycle decision pulse and its outcome
//   gt, eq, lt               : flags of the last compare (held until next CMP)
//   pc_write                 : PCWrite | (done & taken), combinational
//   taken_cnt, not_taken_cnt : statistics (BRANCH_STATS_EN only)
module branch_resolve_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             is_unsigned,
    input  logic [2:0]       branch_ctrl,
    input  logic             PCWrite,
    input  logic             PCWriteCond,
    output logic             done,
    output logic             taken,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             pc_write
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] not_taken_cnt
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_RES  = 2'd2;

    if (CNT_W == 0) begin : g_cnt_w_invalid
        $error("CNT_W must be nonzero");
    end

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             uns_q;
    logic [2:0]       ctrl_q;
    logic             cond_q;
    logic             accept_c;
    logic             gt_c;
    logic             eq_c;
    logic             lt_c;
    logic             cond_met_c;
    logic             res_taken_c;

    // Requests are only taken in IDLE with ready high; the done cycle keeps ready low.
    assign accept_c = req_valid && req_ready && (state == S_IDLE);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept_c) state_nxt = S_CMP;
            S_CMP:   state_nxt = S_RES;
            S_RES:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Magnitude compare of the latched operands; gt is whatever is neither eq nor lt
    always_comb begin
        eq_c = (a_q == b_q);
        if (uns_q) begin
            lt_c = (a_q < b_q);
        end else begin
            lt_c = ($signed(a_q) < $signed(b_q));
        end
        gt_c = !eq_c && !lt_c;
    end

    // Condition evaluation from the registered flags
    always_comb begin
        cond_met_c = 1'b0;
        case (ctrl_q)
            3'b000:  cond_met_c = gt;
            3'b001:  cond_met_c = !gt;
            3'b010:  cond_met_c = !eq;
            3'b011:  cond_met_c = eq;
            3'b100:  cond_met_c = lt;
            3'b101:  cond_met_c = !lt;
            3'b110:  cond_met_c = 1'b1;
            default: cond_met_c = 1'b0;
        endcase
        res_taken_c = cond_met_c && cond_q;
    end

    // Request latch, flags and decision pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_ready <= 1'b1;
            done      <= 1'b0;
            taken     <= 1'b0;
            gt        <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            uns_q     <= 1'b0;
            ctrl_q    <= 3'b000;
            cond_q    <= 1'b0;
        end else begin
            done  <= 1'b0;
            taken <= 1'b0;
            if (accept_c) begin
                a_q       <= op_a;
                b_q       <= op_b;
                uns_q     <= is_unsigned;
                ctrl_q    <= branch_ctrl;
                cond_q    <= PCWriteCond;
                req_ready <= 1'b0;
            end
            if (state == S_CMP) begin
                gt <= gt_c;
                eq <= eq_c;
                lt <= lt_c;
            end
            if (state == S_RES) begin
                done  <= 1'b1;
                taken <= res_taken_c;
            end
            // Ready returns once the decision pulse has been presented
            if (done) begin
                req_ready <= 1'b1;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    // Saturating outcome counters, updated as each decision resolves
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            taken_cnt     <= '0;
            not_taken_cnt <= '0;
        end else if (state == S_RES) begin
            if (res_taken_c) begin
                if (taken_cnt != {CNT_W{1'b1}}) taken_cnt <= taken_cnt + CNT_W'(1);
            end else begin
                if (not_taken_cnt != {CNT_W{1'b1}}) not_taken_cnt <= not_taken_cnt + CNT_W'(1);
            end
        end
    end
`endif

    assign pc_write = PCWrite || (done && taken);

endmodule
